// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory address/data, decode-side handshake and redirect inputs.
// master = fetch unit; slave = memory, decode and exception logic.
interface instruction_fetch_unit_if;
   logic [31:0] InstrAddress;
   logic [31:0] InstrData;
   logic [31:0] Instruction;
   logic [31:0] InstrPC;
   logic [31:0] PCPlus4;
   logic        Valid;
   logic        Stall;
   logic        Branch;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [25:0] JumpIndex;
   logic        JumpReg;
   logic [31:0] JumpRegTarget;
   logic        Exception;
   logic [31:0] EPC;

   modport master (
      output InstrAddress, Instruction, InstrPC, PCPlus4, Valid, EPC,
      input  InstrData, Stall, Branch, BranchTarget, Jump, JumpIndex,
             JumpReg, JumpRegTarget, Exception
   );

   modport slave (
      input  InstrAddress, Instruction, InstrPC, PCPlus4, Valid, EPC,
      output InstrData, Stall, Branch, BranchTarget, Jump, JumpIndex,
             JumpReg, JumpRegTarget, Exception
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Multi-cycle fetch stage owning the PC; capture lands WAIT_CYCLES+1 edges after the PC changes.
// Backpressure: Stall holds the captured word and ignores redirects; Exception overrides everything but Reset.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h00000000,
   parameter logic [31:0] EXC_VECTOR  = 32'hF0000000,
   parameter int          WAIT_CYCLES = 1
) (
   input logic CLK,
   input logic Reset,
   instruction_fetch_unit_if.master bus
);

   typedef enum logic {S_WAIT, S_ISSUE} state_t;

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

   state_t      state, state_n;
   logic [3:0]  count, count_n;
   logic [31:0] pc, pc_n;
   logic [31:0] instr, instr_n;
   logic [31:0] instr_pc, instr_pc_n;
   logic [31:0] epc, epc_n;
   logic        valid, valid_n;
   logic [31:0] pc_plus4;

   assign pc_plus4 = instr_pc + 32'd4;

   always_comb begin
      state_n    = state;
      count_n    = count;
      pc_n       = pc;
      instr_n    = instr;
      instr_pc_n = instr_pc;
      epc_n      = epc;
      valid_n    = valid;

      if (bus.Exception) begin
         pc_n    = EXC_VECTOR;
         valid_n = 1'b0;
         state_n = S_WAIT;
         count_n = WAIT_CNT;
         epc_n   = valid ? instr_pc : pc;
      end else begin
         case (state)
            S_WAIT: begin
               if (count != 4'd0) begin
                  count_n = count - 4'd1;
               end else begin
                  instr_n    = bus.InstrData;
                  instr_pc_n = pc;
                  pc_n       = pc + 32'd4;
                  valid_n    = 1'b1;
                  state_n    = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!bus.Stall) begin
                  valid_n = 1'b0;
                  count_n = WAIT_CNT;
                  state_n = S_WAIT;
                  // PC already points at the sequential successor; only redirects move it.
                  if (bus.JumpReg)
                     pc_n = {bus.JumpRegTarget[31:2], 2'b00};
                  else if (bus.Jump)
                     pc_n = {pc_plus4[31:28], bus.JumpIndex, 2'b00};
                  else if (bus.Branch)
                     pc_n = {bus.BranchTarget[31:2], 2'b00};
               end
            end
            default: state_n = S_WAIT;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state    <= S_WAIT;
         count    <= WAIT_CNT;
         pc       <= RESET_PC;
         instr    <= 32'd0;
         instr_pc <= 32'd0;
         epc      <= 32'd0;
         valid    <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         pc       <= pc_n;
         instr    <= instr_n;
         instr_pc <= instr_pc_n;
         epc      <= epc_n;
         valid    <= valid_n;
      end
   end

   assign bus.InstrAddress = pc;
   assign bus.Instruction  = instr;
   assign bus.InstrPC      = instr_pc;
   assign bus.PCPlus4      = pc_plus4;
   assign bus.Valid        = valid;
   assign bus.EPC          = epc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: WAIT_CYCLES=1 instance for flow/redirect/exception/reset,
// WAIT_CYCLES=0 instance starting near the top of memory for PC wrap and back-to-back issue.
module tb_instruction_fetch_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic CLK = 1'b0;
   logic Reset0, Reset1;
   int   checks = 0;
   int   failures = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 CLK = ~CLK;

   instruction_fetch_unit_if f0 ();
   instruction_fetch_unit_if f1 ();

   instruction_fetch_unit #(.RESET_PC(32'h00000000), .EXC_VECTOR(32'hF0000000), .WAIT_CYCLES(1))
      dut0 (.CLK(CLK), .Reset(Reset0), .bus(f0));
   instruction_fetch_unit #(.RESET_PC(32'hFFFFFFF8), .EXC_VECTOR(32'hF0000000), .WAIT_CYCLES(0))
      dut1 (.CLK(CLK), .Reset(Reset1), .bus(f1));

   // Program memory: a few fixed words, everything else a function of the address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h00000000: mem = 32'h34080032;
         32'h00000004: mem = 32'hAC080000;
         32'h0000002C: mem = 32'h11450005;
         32'h00000040: mem = 32'h0800000B;
         32'h00000044: mem = 32'hAD280000;
         32'hF0000000: mem = 32'h8C080000;
         default:      mem = a ^ 32'h12345678;
      endcase
   endfunction

   assign f0.InstrData = mem(f0.InstrAddress);
   assign f1.InstrData = mem(f1.InstrAddress);

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = mem(pc);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Wait (bounded) for Valid, check the latency, then pop the scoreboard and compare.
   task automatic expect_fetch(input int d, input int lat);
      int   n;
      int   sz;
      exp_t e;
      n = 0;
      while (!(d == 0 ? f0.Valid : f1.Valid) && n < 20) begin
         tick();
         n++;
      end
      chk($sformatf("latency%0d", d), 32'(n), 32'(lat));
      sz = (d == 0) ? q0.size() : q1.size();
      checks++;
      assert (sz != 0) else begin
         failures++;
         $error("FAIL scoreboard%0d observed=empty expected=entry", d);
      end
      if (sz != 0) begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("instr%0d", d),   d == 0 ? f0.Instruction : f1.Instruction, e.instr);
         chk($sformatf("instrpc%0d", d), d == 0 ? f0.InstrPC : f1.InstrPC, e.pc);
         chk($sformatf("pcplus4_%0d", d), d == 0 ? f0.PCPlus4 : f1.PCPlus4, e.pc + 32'd4);
      end
   endtask

   task automatic clear_inputs();
      f0.Stall = 0; f0.Branch = 0; f0.BranchTarget = 0; f0.Jump = 0; f0.JumpIndex = 0;
      f0.JumpReg = 0; f0.JumpRegTarget = 0; f0.Exception = 0;
      f1.Stall = 0; f1.Branch = 0; f1.BranchTarget = 0; f1.Jump = 0; f1.JumpIndex = 0;
      f1.JumpReg = 0; f1.JumpRegTarget = 0; f1.Exception = 0;
   endtask

   initial begin
      Reset0 = 1'b1;
      Reset1 = 1'b1;
      clear_inputs();
      repeat (2) tick();

      chk("rst_addr",  f0.InstrAddress, 32'h0);
      chk("rst_valid", 32'(f0.Valid), 32'h0);
      chk("rst_instr", f0.Instruction, 32'h0);
      chk("rst_ipc",   f0.InstrPC, 32'h0);
      chk("rst_epc",   f0.EPC, 32'h0);
      chk("rst_addr1", f1.InstrAddress, 32'hFFFFFFF8);

      // Sequential flow: first capture two edges after reset release.
      Reset0 = 1'b0;
      push(0, 32'h0);
      expect_fetch(0, 2);
      chk("addr_after_cap", f0.InstrAddress, 32'h4);
      push(0, 32'h4);
      tick();
      chk("accept_valid", 32'(f0.Valid), 32'h0);
      expect_fetch(0, 2);

      // Branch to 0x40.
      f0.Branch = 1; f0.BranchTarget = 32'h40;
      push(0, 32'h40);
      tick();
      f0.Branch = 0;
      chk("br_addr", f0.InstrAddress, 32'h40);
      expect_fetch(0, 2);

      // j 0x0B -> 0x2C.
      f0.Jump = 1; f0.JumpIndex = 26'h00000B;
      push(0, 32'h2C);
      tick();
      f0.Jump = 0;
      chk("j_addr", f0.InstrAddress, 32'h2C);
      expect_fetch(0, 2);

      // Stall ignores the pending branch.
      f0.Stall = 1; f0.Branch = 1; f0.BranchTarget = 32'h44;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", 32'(f0.Valid), 32'h1);
         chk("stall_instr", f0.Instruction, 32'h11450005);
         chk("stall_addr",  f0.InstrAddress, 32'h30);
      end
      f0.Stall = 0;
      push(0, 32'h44);
      tick();
      f0.Branch = 0;
      chk("br44_addr", f0.InstrAddress, 32'h44);
      expect_fetch(0, 2);

      // All three redirects: JumpReg wins, target aligned.
      f0.Branch = 1; f0.BranchTarget = 32'h80;
      f0.Jump = 1; f0.JumpIndex = 26'h3FFFFFF;
      f0.JumpReg = 1; f0.JumpRegTarget = 32'h191;
      push(0, 32'h190);
      tick();
      f0.Branch = 0; f0.Jump = 0; f0.JumpReg = 0;
      chk("jr_prio_addr", f0.InstrAddress, 32'h190);
      expect_fetch(0, 2);

      // Jump beats Branch.
      f0.Jump = 1; f0.JumpIndex = 26'h0C2;
      f0.Branch = 1; f0.BranchTarget = 32'h500;
      push(0, 32'h308);
      tick();
      f0.Jump = 0; f0.Branch = 0;
      chk("j_prio_addr", f0.InstrAddress, 32'h308);
      expect_fetch(0, 2);

      // Exception while Valid and stalled.
      f0.Stall = 1; f0.Exception = 1;
      tick();
      f0.Stall = 0; f0.Exception = 0;
      chk("exc_addr",  f0.InstrAddress, 32'hF0000000);
      chk("exc_epc",   f0.EPC, 32'h308);
      chk("exc_valid", 32'(f0.Valid), 32'h0);
      push(0, 32'hF0000000);
      expect_fetch(0, 2);

      // Exception held two cycles while in WAIT: EPC takes the PC each time.
      tick();
      chk("seq_addr", f0.InstrAddress, 32'hF0000004);
      f0.Exception = 1;
      tick();
      chk("exc_wait_epc1", f0.EPC, 32'hF0000004);
      chk("exc_wait_addr", f0.InstrAddress, 32'hF0000000);
      tick();
      chk("exc_wait_epc2", f0.EPC, 32'hF0000000);
      f0.Exception = 0;
      push(0, 32'hF0000000);
      expect_fetch(0, 2);

      // Redirects in WAIT are ignored.
      tick();
      f0.Branch = 1; f0.BranchTarget = 32'h500;
      push(0, 32'hF0000004);
      expect_fetch(0, 2);
      f0.Branch = 0;

      // Reset during WAIT after a redirect to 0x200.
      f0.Branch = 1; f0.BranchTarget = 32'h200;
      tick();
      f0.Branch = 0;
      chk("pre_rst_addr", f0.InstrAddress, 32'h200);
      Reset0 = 1'b1;
      tick();
      Reset0 = 1'b0;
      chk("mid_rst_addr",  f0.InstrAddress, 32'h0);
      chk("mid_rst_valid", 32'(f0.Valid), 32'h0);
      chk("mid_rst_instr", f0.Instruction, 32'h0);
      push(0, 32'h0);
      expect_fetch(0, 2);

      // WAIT_CYCLES=0: capture every other cycle, PC wraps to zero.
      Reset1 = 1'b0;
      push(1, 32'hFFFFFFF8);
      expect_fetch(1, 1);
      tick();
      chk("w0_valid_low", 32'(f1.Valid), 32'h0);
      push(1, 32'hFFFFFFFC);
      expect_fetch(1, 1);
      chk("wrap_addr",    f1.InstrAddress, 32'h0);
      chk("wrap_pcplus4", f1.PCPlus4, 32'h0);
      tick();
      chk("w0_valid_low2", 32'(f1.Valid), 32'h0);
      push(1, 32'h0);
      expect_fetch(1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Multi-cycle fetch stage directly upstream of the processor's combinational read-only instruction memory. It owns the program counter and drives the memory address. It waits a parameterised number of cycles for the memory's read delay, then captures the returned word into a fetch register and presents it downstream with a valid/stall handshake. It applies redirects in fixed priority: overflow exception, jr/jalr, j/jal, then taken branch.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on Reset.
EXC_VECTOR, 32'hF0000000, overflow-exception handler address.
WAIT_CYCLES, 1, extra cycles the address is held before capture (legal 0..15; covers memory T_rd).

Ports:
CLK  in  1  clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
InstrAddress  out  32  word address to instruction memory; equals PC register.
InstrData  in  32  instruction word returned by instruction memory.
Instruction  out  32  captured instruction for decode.
InstrPC  out  32  address Instruction was fetched from.
PCPlus4  out  32  InstrPC + 4 (mod 2^32, combinational).
Valid  out  1  Instruction/InstrPC are meaningful.
Stall  in  1  downstream not accepting; hold Instruction.
Branch  in  1  taken branch for current Instruction.
BranchTarget  in  32  full branch target address.
Jump  in  1  j/jal for current Instruction.
JumpIndex  in  26  instruction[25:0] of j/jal.
JumpReg  in  1  jr/jalr for current Instruction.
JumpRegTarget  in  32  rs register value.
Exception  in  1  arithmetic overflow detected.
EPC  out  32  PC of excepting instruction.

Behaviour:
- Reset (overrides everything): PC=RESET_PC, Instruction=0, InstrPC=0, Valid=0, EPC=0, state=WAIT, count=WAIT_CYCLES.
- The implementation uses two states, WAIT and ISSUE, and a 4-bit down-counter.
- WAIT: Valid=0. If count!=0, count decrements. If count==0, next edge does the following:
  - Instruction<=InstrData.
  - InstrPC<=PC.
  - PC<=PC+4 (wraps 32'hFFFFFFFC to 0).
  - Valid<=1.
  - state<=ISSUE.
- Capture therefore occurs WAIT_CYCLES+1 edges after PC changes. With WAIT_CYCLES=0, capture is on the first edge.
- ISSUE, Stall=1: all registers hold. Redirect inputs are ignored.
- ISSUE, Stall=0 (accept): Valid<=0, count<=WAIT_CYCLES, state<=WAIT. PC<=redirect target if any, otherwise PC is unchanged (already +4). Redirect priority:
  1. JumpReg: JumpRegTarget.
  2. Jump: {PCPlus4[31:28], JumpIndex, 2'b00}.
  3. Branch: BranchTarget.
- All redirect targets have bits [1:0] forced to 00.
- Redirect inputs are sampled only on an accept edge and are ignored in WAIT.
- Exception (any state, overrides Stall, capture and redirects; not Reset):
  - PC<=EXC_VECTOR, Valid<=0, state<=WAIT, count<=WAIT_CYCLES.
  - EPC<=InstrPC if Valid, else PC.
- Exception held high for N cycles re-vectors every cycle; EPC updates per the same rule each cycle.
- Steady-state throughput is one instruction per WAIT_CYCLES+2 cycles.
- An X in InstrData is captured unchanged; this block does no decoding.
- Instruction, InstrPC and EPC change only on the edges stated above.

Test Plan:
- Reset, WAIT_CYCLES=1, memory loaded with program 1, Stall=0 -> InstrAddress=0x00. Second edge after Reset drops: Instruction=0x34080032, InstrPC=0, Valid=1, InstrAddress=0x04. Accept -> Valid=0 for 2 cycles, then Instruction=0xAC080000, InstrPC=0x04.
- Instruction=0x0800000B at InstrPC=0x40, Jump=1, JumpIndex=0x00000B, accept -> InstrAddress=0x2C, then Instruction=0x11450005, InstrPC=0x2C.
- Branch=1, BranchTarget=0x44 during ISSUE with Stall=1 for 3 cycles -> no change, Valid stays 1. Stall=0 -> PC=0x44, next Instruction=0xAD280000. Same cycle with Jump=1 and JumpReg=1, JumpRegTarget=0x191 -> PC=0x190 (priority and alignment).
- Exception=1 while Valid=1, InstrPC=0x308, Stall=1 -> next edge: InstrAddress=0xF0000000, EPC=0x308, Valid=0. Then Instruction=0x8C080000, InstrPC=0xF0000000.
- Reset asserted in WAIT with count=1, after a redirect to 0x200 -> next edge: PC=0, Valid=0, count=WAIT_CYCLES. No capture of the 0x200 word.
- WAIT_CYCLES=0: PC wraps from 0xFFFFFFFC -> captured InstrPC=0xFFFFFFFC, InstrAddress=0x00000000, PCPlus4=0. Valid toggles every other cycle with Stall=0.
